// File: rtl/nic_pkg.sv
// Shared constants and the status-word packing for the FIFO-based NIC.
// Address map and status bit positions are shared by RTL and bench.
package nic_pkg;

    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int STAT_NE      = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_CNT_LSB = 8;

    // Low 16 bits of a channel status word; callers zero-extend to the data width.
    function automatic logic [15:0] status_word(input logic [7:0] cnt, input logic full,
                                                input logic empty, input logic err);
        logic [15:0] w;
        w = '0;
        w[STAT_NE]               = !empty;
        w[STAT_FULL]             = full;
        w[STAT_ERR]              = err;
        w[STAT_CNT_LSB +: 8]     = cnt;
        return w;
    endfunction

endpackage

// File: rtl/nic_fifo_sync_fifo.sv
// Single-clock FIFO with combinational head output; pushes when full and pops
// when empty are ignored, judged on the count at the start of the cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wdata;
    end

endmodule

// File: rtl/nic_fifo.sv
// NIC between one router port and one PE: input and output FIFOs, PE register
// interface with status/sticky errors, and polarity-gated egress to the router.
module nic_fifo
    import nic_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nicEn,
    input  logic              nicWrEN,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              net_si,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_ri,
    input  logic              net_ro,
    input  logic              net_polarity,
    output logic              net_so,
    output logic [DATA_W-1:0] net_do
);

    logic [DATA_W-1:0]          in_head, out_head;
    logic                       in_full, in_empty, out_full, out_empty;
    logic [$clog2(IN_DEPTH):0]  in_count;
    logic [$clog2(OUT_DEPTH):0] out_count;

    logic pe_rd, pe_wr;
    logic in_pop_req, in_pop, in_underflow, in_push, in_drop, in_stat_rd;
    logic out_push_req, out_push, out_overflow, out_stat_rd, egress;

    logic in_drop_err_reg, in_drop_err_next;
    logic in_underflow_err_reg, in_underflow_err_next;
    logic out_overflow_err_reg, out_overflow_err_next;
    logic [DATA_W-1:0] d_out_reg, d_out_next;
    logic [DATA_W-1:0] net_do_reg;
    logic              net_so_reg;
    logic [DATA_W-1:0] in_stat, out_stat;

    assign pe_rd        = nicEn && !nicWrEN;
    assign pe_wr        = nicEn && nicWrEN;
    assign in_pop_req   = pe_rd && (addr == ADDR_IN_DATA);
    assign in_stat_rd   = pe_rd && (addr == ADDR_IN_STAT);
    assign out_stat_rd  = pe_rd && (addr == ADDR_OUT_STAT);
    assign out_push_req = pe_wr && (addr == ADDR_OUT_DATA);

    assign in_push      = net_si && !in_full;
    assign in_drop      = net_si && in_full;
    assign in_pop       = in_pop_req && !in_empty;
    assign in_underflow = in_pop_req && in_empty;
    assign out_push     = out_push_req && !out_full;
    assign out_overflow = out_push_req && out_full;
    assign egress       = !out_empty && net_ro && (net_polarity == out_head[DATA_W-1]);

    assign net_ri = !in_full;
    assign d_out  = d_out_reg;
    assign net_do = net_do_reg;
    assign net_so = net_so_reg;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (net_di),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (egress),
        .wdata (d_in),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    assign in_stat  = DATA_W'(status_word(8'(in_count), in_full, in_empty,
                                          in_drop_err_reg | in_underflow_err_reg));
    assign out_stat = DATA_W'(status_word(8'(out_count), out_full, out_empty,
                                          out_overflow_err_reg));

    // A status read clears its channel's errors, but a fresh error on the same edge wins.
    always_comb begin
        in_drop_err_next      = (in_drop_err_reg && !in_stat_rd) || in_drop;
        in_underflow_err_next = (in_underflow_err_reg && !in_stat_rd) || in_underflow;
        out_overflow_err_next = (out_overflow_err_reg && !out_stat_rd) || out_overflow;
    end

    always_comb begin
        d_out_next = d_out_reg;
        if (in_pop)
            d_out_next = in_head;
        else if (pe_rd && (addr != ADDR_IN_DATA))
            d_out_next = addr[1] ? out_stat : in_stat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_drop_err_reg      <= 1'b0;
            in_underflow_err_reg <= 1'b0;
            out_overflow_err_reg <= 1'b0;
            d_out_reg            <= '0;
            net_do_reg           <= '0;
            net_so_reg           <= 1'b0;
        end else begin
            in_drop_err_reg      <= in_drop_err_next;
            in_underflow_err_reg <= in_underflow_err_next;
            out_overflow_err_reg <= out_overflow_err_next;
            d_out_reg            <= d_out_next;
            net_so_reg           <= egress;
            if (egress)
                net_do_reg <= out_head;
        end
    end

endmodule

// File: tb/tb_nic_fifo.sv
// Directed table-driven bench for nic_fifo plus hand-written egress polarity sequences.
module tb_nic_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        nicEn, nicWrEN;
    logic [1:0]  addr;
    logic [63:0] d_in, d_out;
    logic        net_si;
    logic [63:0] net_di;
    logic        net_ri, net_ro, net_polarity, net_so;
    logic [63:0] net_do;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nic_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .nicEn        (nicEn),
        .nicWrEN      (nicWrEN),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .net_si       (net_si),
        .net_di       (net_di),
        .net_ri       (net_ri),
        .net_ro       (net_ro),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_do       (net_do)
    );

    typedef struct {
        logic        rst, en, wr;
        logic [1:0]  a;
        logic [63:0] d;
        logic        si;
        logic [63:0] di;
        logic        ro, pol;
        logic [63:0] exp_dout;
        logic        exp_ri, exp_so;
        logic [63:0] exp_do;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, en, wr, input logic [1:0] a, input logic [63:0] d,
                       input logic si, input logic [63:0] di, input logic ro, pol,
                       input logic [63:0] ed, input logic eri, eso, input logic [63:0] edo);
        vec_t v;
        v.rst = rst; v.en = en; v.wr = wr; v.a = a; v.d = d;
        v.si = si; v.di = di; v.ro = ro; v.pol = pol;
        v.exp_dout = ed; v.exp_ri = eri; v.exp_so = eso; v.exp_do = edo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic rst, en, wr, input logic [1:0] a, input logic [63:0] d,
                        input logic si, input logic [63:0] di, input logic ro, pol);
        @(negedge clk);
        reset = rst; nicEn = en; nicWrEN = wr; addr = a; d_in = d;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] PKT_AA = 64'h8000_0000_0000_00AA;
    localparam logic [63:0] PKT_A  = 64'h0000_0000_0000_00A0;
    localparam logic [63:0] PKT_B  = 64'h8000_0000_0000_00B0;

    initial begin
        int pulses;
        reset = 1'b1; nicEn = 0; nicWrEN = 0; addr = 0; d_in = 0;
        net_si = 0; net_di = 0; net_ro = 0; net_polarity = 0;

        //   rst en wr a      d       si di     ro pol  d_out    ri so net_do
        // Input channel: fill, drop, status clear, ordered pops, underflow.
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'h11,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'h22,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'h33,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'h44,  0, 0,   64'h0,   0, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'h55,  0, 0,   64'h0,   0, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h407, 0, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h403, 0, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h11,  1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h22,  1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h33,  1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h44,  1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h44,  1, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h4,   1, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        // Simultaneous push/pop: legal when non-empty, pop rejected when empty.
        add(0, 0, 0, 2'b00, 0,      1, 'h66,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      1, 'h77,  0, 0,   64'h66,  1, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h101, 1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h77,  1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      1, 'h88,  0, 0,   64'h77,  1, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h105, 1, 0, 64'h0);
        add(0, 1, 0, 2'b00, 0,      0, 0,     0, 0,   64'h88,  1, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        // Error on the same edge as a status read stays set; then mid-run reset flushes.
        add(0, 0, 0, 2'b00, 0,      1, 'hA1,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'hA2,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'hA3,  0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      1, 'hA4,  0, 0,   64'h0,   0, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      1, 'hA5,  0, 0,   64'h403, 0, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h407, 0, 0, 64'h0);
        add(1, 0, 0, 2'b00, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        // Output channel: overflow, egress alongside PE push, full-with-pop rejection.
        add(0, 1, 1, 2'b10, 'h01,   0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 1, 2'b10, 'h02,   0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 1, 2'b10, 'h03,   0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 1, 2'b10, 'h04,   0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 1, 2'b10, 'h05,   0, 0,     0, 0,   64'h0,   1, 0, 64'h0);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h407, 1, 0, 64'h0);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h403, 1, 0, 64'h0);
        add(0, 0, 0, 2'b00, 0,      0, 0,     1, 0,   64'h403, 1, 1, 64'h01);
        add(0, 1, 1, 2'b10, 'h06,   0, 0,     1, 0,   64'h403, 1, 1, 64'h02);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h301, 1, 0, 64'h02);
        add(0, 1, 1, 2'b10, 'h07,   0, 0,     0, 0,   64'h301, 1, 0, 64'h02);
        add(0, 1, 1, 2'b10, 'h08,   0, 0,     1, 0,   64'h301, 1, 1, 64'h03);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h305, 1, 0, 64'h03);
        add(0, 0, 0, 2'b00, 0,      0, 0,     1, 1,   64'h305, 1, 0, 64'h03);
        add(0, 0, 0, 2'b00, 0,      0, 0,     1, 0,   64'h305, 1, 1, 64'h04);
        add(0, 0, 0, 2'b00, 0,      0, 0,     1, 0,   64'h305, 1, 1, 64'h06);
        add(0, 0, 0, 2'b00, 0,      0, 0,     1, 0,   64'h305, 1, 1, 64'h07);
        add(0, 0, 0, 2'b00, 0,      0, 0,     1, 0,   64'h305, 1, 0, 64'h07);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h07);
        // Writes to non-data addresses have no effect.
        add(0, 1, 1, 2'b00, 'hDEAD, 0, 0,     0, 0,   64'h0,   1, 0, 64'h07);
        add(0, 1, 1, 2'b01, 'hBEEF, 0, 0,     0, 0,   64'h0,   1, 0, 64'h07);
        add(0, 1, 1, 2'b11, 'hCAFE, 0, 0,     0, 0,   64'h0,   1, 0, 64'h07);
        add(0, 1, 0, 2'b01, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h07);
        add(0, 1, 0, 2'b11, 0,      0, 0,     0, 0,   64'h0,   1, 0, 64'h07);

        repeat (2) @(posedge clk);
        #1;
        check("reset d_out", d_out, 64'h0);
        check("reset net_ri", 64'(net_ri), 64'h1);
        check("reset net_so", 64'(net_so), 64'h0);
        check("reset net_do", net_do, 64'h0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].a, vecs[i].d,
                 vecs[i].si, vecs[i].di, vecs[i].ro, vecs[i].pol);
            check($sformatf("vec%0d d_out", i),  d_out,          vecs[i].exp_dout);
            check($sformatf("vec%0d net_ri", i), 64'(net_ri),    64'(vecs[i].exp_ri));
            check($sformatf("vec%0d net_so", i), 64'(net_so),    64'(vecs[i].exp_so));
            check($sformatf("vec%0d net_do", i), net_do,         vecs[i].exp_do);
            $display("vec %0d: addr=%b en=%b wr=%b si=%b ro=%b pol=%b -> d_out=%h ri=%b so=%b do=%h",
                     i, vecs[i].a, vecs[i].en, vecs[i].wr, vecs[i].si, vecs[i].ro, vecs[i].pol,
                     d_out, net_ri, net_so, net_do);
        end

        // Polarity toggling every cycle: the MSB=1 packet leaves on the first pol=1 edge only.
        step(0, 1, 1, 2'b10, PKT_AA, 0, 0, 0, 0);
        check("toggle write so", 64'(net_so), 64'h0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 2'b00, 0, 0, 0, 1, logic'(c % 2));
            if (net_so) pulses++;
            check($sformatf("toggle c%0d net_so", c), 64'(net_so), (c == 1) ? 64'h1 : 64'h0);
            if (c == 1) check("toggle net_do", net_do, PKT_AA);
            $display("toggle cycle %0d: pol=%0d so=%b do=%h", c, c % 2, net_so, net_do);
        end
        check("toggle pulse count", 64'(pulses), 64'h1);
        step(0, 1, 0, 2'b11, 0, 0, 0, 0, 0);
        check("toggle status 11", d_out, 64'h0);

        // Head-of-line blocking: A (MSB 0) holds back B (MSB 1) while polarity is 1.
        step(0, 1, 1, 2'b10, PKT_A, 0, 0, 1, 1);
        check("hol write A so", 64'(net_so), 64'h0);
        step(0, 1, 1, 2'b10, PKT_B, 0, 0, 1, 1);
        check("hol write B so", 64'(net_so), 64'h0);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 2'b00, 0, 0, 0, 1, 1);
            check($sformatf("hol blocked c%0d so", c), 64'(net_so), 64'h0);
            $display("hol blocked cycle %0d: so=%b", c, net_so);
        end
        step(0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
        check("hol A so", 64'(net_so), 64'h1);
        check("hol A do", net_do, PKT_A);
        step(0, 0, 0, 2'b00, 0, 0, 0, 1, 1);
        check("hol B so", 64'(net_so), 64'h1);
        check("hol B do", net_do, PKT_B);
        $display("hol: A then B sent, last do=%h", net_do);
        step(0, 1, 0, 2'b11, 0, 0, 0, 0, 0);
        check("hol idle so", 64'(net_so), 64'h0);
        check("hol status 11", d_out, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nic_fifo.md
Name: nic_fifo

Overview:
- Parametrised successor to the single-entry NIC: sits between one router port and one PE.
- Replaces each one-packet channel buffer with a DEPTH-entry FIFO, adds occupancy/status reporting and sticky error flags.
- Keeps the polarity-gated send to the router: a packet leaves only when its MSB equals net_polarity.

Parameters:
- DATA_W, 64, packet/data width; bit DATA_W-1 is the packet's polarity (VC) bit
- IN_DEPTH, 4, input FIFO entries (router→PE); power of two, ≥2
- OUT_DEPTH, 4, output FIFO entries (PE→router); power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- nicEn  in  1  PE access enable
- nicWrEN  in  1  1 = PE write, 0 = PE read
- addr  in  2  register select
- d_in  in  DATA_W  PE write data
- d_out  out  DATA_W  PE read data, registered
- net_si  in  1  router presents valid packet on net_di
- net_di  in  DATA_W  packet from router
- net_ri  out  1  input FIFO can accept a packet
- net_ro  in  1  router can accept a packet
- net_polarity  in  1  current network polarity
- net_so  out  1  net_do valid this cycle
- net_do  out  DATA_W  packet to router, registered

Behaviour:
- Reset: both FIFOs empty, errors clear, d_out=0, net_do=0, net_so=0. net_ri is high after reset (IN_DEPTH>0).
- net_ri = !in_full. Combinational from registered count, so no extra latency.
- Router ingress: net_si && net_ri at a posedge → push net_di. net_si while full → dropped, in_drop_err set.
- Address map, PE side:
  - 00 read: pop input FIFO. d_out = head next cycle.
  - 01 read: input status.
  - 10 write: push d_in to output FIFO.
  - 11 read: output status.
  - 00 write, 01 write, 11 write: ignored.
  - Status word: bit0 = not-empty, bit1 = full, bit2 = sticky error, bits[15:8] = count, other bits 0.
  - A status read clears that channel's sticky error on the same edge. An error event on that same edge wins, so the bit stays set.
- Read of addr 00 when input FIFO empty: d_out holds its old value, no pop, in_underflow_err set. The input error bit = in_drop_err | in_underflow_err.
- Write of addr 10 when output FIFO full: write discarded, out_overflow_err set.
- Full/empty decisions use the count at the start of the cycle.
- Simultaneous push and pop on one FIFO:
  - Both occur when legal; count unchanged.
  - When full, a push is rejected even if a pop happens in the same cycle.
  - When empty, a pop is rejected even if a push happens in the same cycle.
- PE read of a non-00 address: d_out updated to the status word. When nicEn=0, d_out holds.
- Egress: if output not empty && net_ro && net_polarity==head[DATA_W-1], then at the edge net_do<=head, net_so<=1, pop. Otherwise net_so<=0 and net_do holds.
  - Strict FIFO order: a head with the wrong polarity blocks later packets.
  - Maximum throughput is 1 packet per 2 cycles when polarity toggles every cycle.
- A PE push and an egress pop in the same cycle on a non-full FIFO both succeed.
- Reset mid-operation flushes all FIFO contents. Packets not yet popped are lost.
- Pointers wrap modulo depth. Count width is $clog2(DEPTH)+1.

Decomposition:
- Package nic_pkg holds:
  - address constants: ADDR_IN_DATA=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_DATA=2'b10, ADDR_OUT_STAT=2'b11
  - status bit positions: STAT_NE=0, STAT_FULL=1, STAT_ERR=2, STAT_CNT_LSB=8
- Sub-module sync_fifo(WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata (head, combinational), full, empty, count; pop ignored when empty, push ignored when full
  - instantiated twice: input and output channels
- Top level holds the register decode, error flags, egress gating and output registers.

Test Plan:
- Reset, then read addr 01 and 11 → d_out=0 both; net_ri=1, net_so=0.
- Router pushes 0x11, 0x22, 0x33, 0x44 (IN_DEPTH=4) → net_ri=0 after the 4th. A 5th net_si is dropped; status 01 reads 0x0000_0407. The next status read reads 0x0000_0403 (error cleared). Four addr-00 reads return 0x11, 0x22, 0x33, 0x44 in order; net_ri returns to 1 after the first pop.
- Addr-00 read while empty → d_out unchanged; following status 01 read shows bit2=1.
- PE writes 0x8000_0000_0000_00AA with net_ro=1, polarity toggling → net_so pulses exactly once, on the first edge with polarity=1, net_do=0x8000…00AA; status 11 then reads 0.
- PE writes packets A (MSB 0) then B (MSB 1); net_polarity held at 1 → nothing sent (A blocks B). Polarity changes to 0 → A sent; polarity 1 → B sent.
- Output FIFO full, net_ro=0 → 5th addr-10 write discarded, bit2 set in status 11. Same-cycle PE write and egress pop on a FIFO with 3 entries → count stays 3.
